ball_controller: RTL and testbench



---
 rtl/ball_controller.sv | 184 ++++++++++++++++++
 tb/tb_ball_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ball_controller.sv
// ball_controller: ball motion stage fed by the paddle controller.
// Tracks the paddle while ATTACHED, flies the ball on a divided motion tick
// while MOVING (wall / paddle bounces), loses a life when the ball reaches the
// floor, and stops in OVER once the lives are exhausted.
//
// Ports:
//   CLOCK_50            system clock, rising edge
//   reset               synchronous, active-high
//   launch_button       active-low launch request (already synchronised)
//   player_x/player_y   paddle top-left position
//   ball_x/ball_y       ball top-left position (registered)
//   ball_active         high while MOVING
//   ball_lost           one-cycle pulse on ball loss
//   lives               remaining lives
//   game_over           high in OVER
//
// Optional feature: define BALL_SPEEDUP_EN to raise the step by one pixel every
// 8th paddle hit, up to MAX_STEP. Without it the step is the constant STEP.
module ball_controller #(
  parameter int BALL_SIZE  = 8,
  parameter int PADDLE_W   = 32,
  parameter int STEP       = 2,
  parameter int TICK_DIV   = 1250000,
  parameter int LIVES_INIT = 3,
  parameter int MAX_STEP   = 6
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       launch_button,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_active,
  output logic       ball_lost,
  output logic [1:0] lives,
  output logic       game_over
);
  localparam int SCR_W   = 640;
  localparam int SCR_H   = 480;
  localparam int CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Step register is sized for the larger of the start and ceiling values.
  localparam int STEP_HI = (MAX_STEP > STEP) ? MAX_STEP : STEP;
  localparam int SW      = $clog2(STEP_HI + 1);

  localparam logic [CW-1:0] TC    = CW'(TICK_DIV - 1);
  localparam logic [10:0]   BS    = 11'(BALL_SIZE);
  localparam logic [10:0]   PW    = 11'(PADDLE_W);
  localparam logic [10:0]   X_MAX = 11'(SCR_W - BALL_SIZE);
  localparam logic [10:0]   Y_MAX = 11'(SCR_H - BALL_SIZE);
  localparam logic [10:0]   FLOOR = 11'(SCR_H);
  // Ball parked on the paddle's own reset position (304,460).
  localparam logic [9:0]    X_RST = 10'd316;
  localparam logic [9:0]    Y_RST = 10'd452;

  typedef enum logic [1:0] {ATTACHED, MOVING, LOST, OVER} state_t;

  state_t        state;
  logic          armed;
  logic          dx, dy;      // 1 = +1 (right / down), 0 = -1
  logic [CW-1:0] cnt;
  logic [SW-1:0] step;

`ifdef BALL_SPEEDUP_EN
  logic [2:0]    hit_cnt;
`else
  assign step = SW'(STEP);
`endif

  // 11-bit unsigned intermediates so nothing wraps at the screen edges.
  logic [10:0] bx, by, px, py, stp, att_x, att_y, att_x_raw, att_y_raw;
  logic        hit_left, hit_right, hit_top, hit_pad, hit_floor, pad_dx;

  assign bx  = {1'b0, ball_x};
  assign by  = {1'b0, ball_y};
  assign px  = {1'b0, player_x};
  assign py  = {1'b0, player_y};
  assign stp = 11'(step);

  // Resting spot on the paddle; also the landing height after a paddle hit.
  assign att_x_raw = px + PW / 2 - BS / 2;
  assign att_y_raw = (py >= BS) ? py - BS : 11'd0;
  assign att_x     = (att_x_raw > X_MAX) ? X_MAX : att_x_raw;
  assign att_y     = (att_y_raw > Y_MAX) ? Y_MAX : att_y_raw;

  assign hit_left  = !dx && (bx < stp);
  assign hit_right =  dx && (bx + stp > X_MAX);
  assign hit_top   = !dy && (by < stp);
  assign hit_pad   =  dy && (by + BS <= py) && (by + BS + stp >= py) &&
                      (bx + BS > px) && (bx < px + PW);
  assign hit_floor =  dy && !hit_pad && (by + BS + stp >= FLOOR);
  // Ball centre left of paddle centre sends it left.
  assign pad_dx    = (bx + BS / 2) >= (px + PW / 2);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= ATTACHED;
      armed       <= 1'b0;
      ball_x      <= X_RST;
      ball_y      <= Y_RST;
      dx          <= 1'b1;
      dy          <= 1'b0;
      cnt         <= '0;
      ball_active <= 1'b0;
      ball_lost   <= 1'b0;
      game_over   <= 1'b0;
      lives       <= 2'(LIVES_INIT);
`ifdef BALL_SPEEDUP_EN
      step        <= SW'(STEP);
      hit_cnt     <= 3'd0;
`endif
    end else begin
      case (state)
        ATTACHED: begin
          ball_x <= att_x[9:0];
          ball_y <= att_y[9:0];
          // Launch needs a released button first, so a held button after a
          // loss cannot relaunch by itself.
          if (launch_button) armed <= 1'b1;
          else if (armed) begin
            state       <= MOVING;
            dx          <= 1'b1;
            dy          <= 1'b0;
            cnt         <= '0;
            ball_active <= 1'b1;
          end
        end
        MOVING: begin
          if (cnt != TC) cnt <= cnt + CW'(1);
          else begin
            cnt <= '0;
            if (hit_floor) begin
              // Position frozen where the ball fell through.
              state       <= LOST;
              ball_lost   <= 1'b1;
              ball_active <= 1'b0;
            end else begin
              if (hit_left) begin
                ball_x <= 10'd0;
                dx     <= 1'b1;
              end else if (hit_right) begin
                ball_x <= X_MAX[9:0];
                dx     <= 1'b0;
              end else begin
                ball_x <= dx ? ball_x + stp[9:0] : ball_x - stp[9:0];
              end

              if (hit_top) begin
                ball_y <= 10'd0;
                dy     <= 1'b1;
              end else if (hit_pad) begin
                ball_y <= att_y[9:0];
                dy     <= 1'b0;
                dx     <= pad_dx;   // paddle decides the new horizontal heading
`ifdef BALL_SPEEDUP_EN
                hit_cnt <= hit_cnt + 3'd1;
                if (hit_cnt == 3'd7 && step < SW'(MAX_STEP)) step <= step + SW'(1);
`endif
              end else begin
                ball_y <= dy ? ball_y + stp[9:0] : ball_y - stp[9:0];
              end
            end
          end
        end
        LOST: begin
          ball_lost <= 1'b0;
          armed     <= 1'b0;
          lives     <= lives - 2'd1;
`ifdef BALL_SPEEDUP_EN
          step      <= SW'(STEP);
          hit_cnt   <= 3'd0;
`endif
          if (lives == 2'd1) begin
            state     <= OVER;
            game_over <= 1'b1;
          end else begin
            state <= ATTACHED;
          end
        end
        default: ;  // OVER: everything held until reset
      endcase
    end
  end
endmodule

// File: tb/tb_ball_controller.sv
// Directed bench for ball_controller with TICK_DIV=4. A per-tick table drives
// the paddle and checks the ball through a corner double bounce and two paddle
// hits; hand sequences cover reset, tracking, launch timing, ball loss, lives,
// game over and (with BALL_SPEEDUP_EN) the step increase.
module tb_ball_controller;
  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       launch_button = 1'b1;
  logic [9:0] player_x = 10'd304;
  logic [9:0] player_y = 10'd460;
  logic [9:0] ball_x, ball_y;
  logic       ball_active, ball_lost, game_over;
  logic [1:0] lives;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ball_controller #(.TICK_DIV(TICK)) dut (
    .CLOCK_50(clk), .reset(reset), .launch_button(launch_button),
    .player_x(player_x), .player_y(player_y),
    .ball_x(ball_x), .ball_y(ball_y), .ball_active(ball_active),
    .ball_lost(ball_lost), .lives(lives), .game_over(game_over)
  );

  typedef struct {
    int px, py;   // paddle held during these ticks
    int ticks;    // motion ticks to run
    int ex, ey;   // ball position after the last tick
  } vec_t;

  vec_t tbl [13];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  initial begin
    int k;
    // Ball launched from (13,4) flies up-right, bounces off the top, then is
    // caught at y=0 by a paddle at (8,8) on every other tick, heading left
    // until it reaches x=1 going up-left: both axes flip on the same tick.
    tbl[0]  = '{8, 8, 1, 15, 2};
    tbl[1]  = '{8, 8, 1, 17, 0};
    tbl[2]  = '{8, 8, 1, 19, 0};   // top bounce
    tbl[3]  = '{8, 8, 1, 21, 0};   // paddle hit, dx -> -1
    tbl[4]  = '{8, 8, 1, 19, 0};
    tbl[5]  = '{8, 8, 8, 3, 0};
    tbl[6]  = '{8, 8, 1, 1, 0};
    tbl[7]  = '{8, 8, 1, 0, 0};    // corner: x and y flip together
    tbl[8]  = '{8, 8, 1, 2, 2};    // now down-right
    tbl[9]  = '{40, 50, 20, 42, 42}; // hit at (40,40), centre left -> dx -1
    tbl[10] = '{40, 50, 1, 40, 40};
    tbl[11] = '{40, 70, 52, 62, 62}; // hit at (60,60), centre right -> dx +1
    tbl[12] = '{40, 70, 1, 64, 60};

    // ---- reset and tracking ----
    cyc(2);
    chk("rst_x", 32'(ball_x), 316);
    chk("rst_y", 32'(ball_y), 452);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_active", 32'(ball_active), 0);
    chk("rst_lost", 32'(ball_lost), 0);
    chk("rst_over", 32'(game_over), 0);
    reset = 1'b0;
    cyc(1);
    player_x = 10'd100;
    cyc(1);
    chk("track_x", 32'(ball_x), 112);
    chk("track_y", 32'(ball_y), 452);

    // ---- launch and first motion ----
    player_x = 10'd304;
    cyc(1);
    launch_button = 1'b0;
    cyc(1);
    chk("launch_active", 32'(ball_active), 1);
    cyc(TICK - 1);
    chk("pre_tick_x", 32'(ball_x), 316);
    cyc(1);
    chk("tick1_x", 32'(ball_x), 318);
    chk("tick1_y", 32'(ball_y), 450);
    cyc(TICK);
    chk("tick2_x", 32'(ball_x), 320);
    chk("tick2_y", 32'(ball_y), 448);
    reset = 1'b1;
    cyc(1);
    chk("rst_mid_active", 32'(ball_active), 0);
    chk("rst_mid_x", 32'(ball_x), 316);

    // ---- table: corner double flip and paddle hits ----
    launch_button = 1'b1; player_x = 10'd1; player_y = 10'd12;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    chk("att_x", 32'(ball_x), 13);
    chk("att_y", 32'(ball_y), 4);
    launch_button = 1'b0;
    cyc(1);
    chk("launch2_active", 32'(ball_active), 1);
    for (int i = 0; i < 13; i++) begin
      player_x = 10'(tbl[i].px);
      player_y = 10'(tbl[i].py);
      repeat (tbl[i].ticks) cyc(TICK);
      chk($sformatf("tbl%0d_x", i), 32'(ball_x), tbl[i].ex);
      chk($sformatf("tbl%0d_y", i), 32'(ball_y), tbl[i].ey);
    end

    // ---- three losses, game over ----
    // Launch from (12,0); top bounce, then the ball falls with no paddle in
    // reach and is lost at y=470 with x frozen at 484.
    reset = 1'b1; launch_button = 1'b1; player_x = 10'd0; player_y = 10'd8;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    for (int l = 3; l >= 1; l--) begin
      launch_button = 1'b1;
      cyc(1);
      launch_button = 1'b0;
      cyc(1);
      chk("relaunch_active", 32'(ball_active), 1);
      player_y = 10'd0;
      k = 0;
      while (!ball_lost && k < 2000) begin
        cyc(1);
        k++;
      end
      chk("lost_pulse", 32'(ball_lost), 1);
      chk("lost_lives_hold", 32'(lives), 32'(l));
      chk("lost_active", 32'(ball_active), 0);
      chk("lost_y", 32'(ball_y), 470);
      chk("lost_x", 32'(ball_x), 484);
      player_y = 10'd8;
      cyc(1);
      chk("lost_one_cycle", 32'(ball_lost), 0);
      chk("lives_dec", 32'(lives), 32'(l - 1));
      chk("over_flag", 32'(game_over), (l == 1) ? 1 : 0);
      if (l > 1) begin
        cyc(10);
        chk("held_button_blocked", 32'(ball_active), 0);
      end
    end
    launch_button = 1'b1;
    cyc(2);
    launch_button = 1'b0;
    cyc(2);
    chk("over_hold", 32'(game_over), 1);
    chk("over_active", 32'(ball_active), 0);
    chk("over_lives", 32'(lives), 0);
    chk("over_frozen_y", 32'(ball_y), 470);
    reset = 1'b1;
    cyc(1);
    chk("rst_lives_back", 32'(lives), 3);
    chk("rst_over_clr", 32'(game_over), 0);

`ifdef BALL_SPEEDUP_EN
    // Ball pinned at y=0: top bounce and paddle hit alternate every tick.
    for (int r = 0; r < 2; r++) begin
      int hits, exp_step;
      hits = (r == 0) ? 8 : 40;
      exp_step = (r == 0) ? 3 : 6;
      reset = 1'b1; launch_button = 1'b1; player_x = 10'd0; player_y = 10'd8;
      cyc(2);
      reset = 1'b0;
      cyc(1);
      launch_button = 1'b0;
      cyc(1);
      for (int t = 0; t < 2 * hits; t++) begin
        player_x = ball_x;
        cyc(TICK);
      end
      cyc(TICK);
      player_y = 10'd0;
      cyc(TICK);
      chk("speedup_step", 32'(ball_y), 32'(exp_step));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
